// File: rtl/issue_queue_int_if.sv
// Dispatch / CDB / issue bundle between the dispatch stage, issue queue and issue unit.
// master: drives dispatch, CDB, flush and issue grant; observes queue status and selected entry.
// slave : the issue queue itself.
interface issue_queue_int_if;
    logic        dispatch_valid;
    logic [3:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata;
    logic [31:0] dispatch_rtdata;
    logic [5:0]  dispatch_rstag;
    logic [5:0]  dispatch_rttag;
    logic        dispatch_rsvalid;
    logic        dispatch_rtvalid;
    logic [5:0]  dispatch_rdtag;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        flush;
    logic        issue_int;
    logic        issuequeue_full;
    logic        issuequeue_ready;
    logic        ready_int;
    logic [3:0]  opcode;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [5:0]  rdtag;

    modport master (
        output dispatch_valid, dispatch_opcode, dispatch_rsdata, dispatch_rtdata,
               dispatch_rstag, dispatch_rttag, dispatch_rsvalid, dispatch_rtvalid,
               dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, flush, issue_int,
        input  issuequeue_full, issuequeue_ready, ready_int, opcode, rsdata, rtdata, rdtag
    );

    modport slave (
        input  dispatch_valid, dispatch_opcode, dispatch_rsdata, dispatch_rtdata,
               dispatch_rstag, dispatch_rttag, dispatch_rsvalid, dispatch_rtvalid,
               dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, flush, issue_int,
        output issuequeue_full, issuequeue_ready, ready_int, opcode, rsdata, rtdata, rdtag
    );
endinterface

// File: rtl/issue_queue_int.sv
// Integer issue queue: age-ordered compacting array of DEPTH entries with CDB wakeup,
// dispatch-time CDB forwarding and oldest-ready select.
// Ports: clk, reset (async, active-high), bus (issue_queue_int_if.slave) carrying
// dispatch, CDB, flush, issue grant inputs and full/ready status plus selected-entry outputs.
module issue_queue_int #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic               clk,
    input logic               reset,
    issue_queue_int_if.slave  bus
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned IDX_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              v;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] rs;
        logic [TAG_W-1:0]  rstag;
        logic              rsv;
        logic [DATA_W-1:0] rt;
        logic [TAG_W-1:0]  rttag;
        logic              rtv;
        logic [TAG_W-1:0]  rd;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    entry_t             woke  [DEPTH+1];   // extra always-empty slot feeds the top on a shift
    entry_t             new_ent;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               nempty_q, nempty_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               issue_fire;
    logic               accept;
    logic [CNT_W-1:0]   wr_idx;

    // Oldest (lowest-index) entry with both operands ready.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ent_q[i].v && ent_q[i].rsv && ent_q[i].rtv) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Selected-entry outputs, zeroed when nothing is ready.
    logic [OP_W-1:0]   op_sel;
    logic [DATA_W-1:0] rs_sel, rt_sel;
    logic [TAG_W-1:0]  rd_sel;

    always_comb begin
        op_sel = '0;
        rs_sel = '0;
        rt_sel = '0;
        rd_sel = '0;
        if (sel_found) begin
            op_sel = ent_q[sel_idx].op;
            rs_sel = ent_q[sel_idx].rs;
            rt_sel = ent_q[sel_idx].rt;
            rd_sel = ent_q[sel_idx].rd;
        end
    end

    assign bus.ready_int        = sel_found;
    assign bus.opcode           = op_sel;
    assign bus.rsdata           = rs_sel;
    assign bus.rtdata           = rt_sel;
    assign bus.rdtag            = rd_sel;
    assign bus.issuequeue_full  = full_q;
    assign bus.issuequeue_ready = nempty_q;

    // Next-state: wakeup, compaction behind the issued slot, dispatch write, flush.
    always_comb begin
        issue_fire = sel_found & bus.issue_int;
        accept     = bus.dispatch_valid & ~full_q & ~bus.flush;
        wr_idx     = count_q - CNT_W'(issue_fire);

        for (int i = 0; i < int'(DEPTH); i++) begin
            woke[i] = ent_q[i];
            if (bus.cdb_valid && woke[i].v && !woke[i].rsv && (woke[i].rstag == bus.cdb_tagout)) begin
                woke[i].rs  = bus.cdb_out;
                woke[i].rsv = 1'b1;
            end
            if (bus.cdb_valid && woke[i].v && !woke[i].rtv && (woke[i].rttag == bus.cdb_tagout)) begin
                woke[i].rt  = bus.cdb_out;
                woke[i].rtv = 1'b1;
            end
        end
        woke[DEPTH] = '0;

        // Incoming operands may be satisfied by this cycle's broadcast.
        new_ent       = '0;
        new_ent.v     = 1'b1;
        new_ent.op    = bus.dispatch_opcode;
        new_ent.rstag = bus.dispatch_rstag;
        new_ent.rttag = bus.dispatch_rttag;
        new_ent.rd    = bus.dispatch_rdtag;
        new_ent.rs    = bus.dispatch_rsdata;
        new_ent.rsv   = bus.dispatch_rsvalid;
        new_ent.rt    = bus.dispatch_rtdata;
        new_ent.rtv   = bus.dispatch_rtvalid;
        if (!bus.dispatch_rsvalid && bus.cdb_valid && (bus.dispatch_rstag == bus.cdb_tagout)) begin
            new_ent.rs  = bus.cdb_out;
            new_ent.rsv = 1'b1;
        end
        if (!bus.dispatch_rtvalid && bus.cdb_valid && (bus.dispatch_rttag == bus.cdb_tagout)) begin
            new_ent.rt  = bus.cdb_out;
            new_ent.rtv = 1'b1;
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
                ent_d[i] = woke[i+1];
            end else begin
                ent_d[i] = woke[i];
            end
            if (accept && (CNT_W'(i) == wr_idx)) begin
                ent_d[i] = new_ent;
            end
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(issue_fire);

        if (bus.flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_d[i].v = 1'b0;
            end
            count_d = '0;
        end

        full_d   = (count_d == CNT_W'(DEPTH));
        nempty_d = (count_d != '0);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            count_q  <= '0;
            full_q   <= 1'b0;
            nempty_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q  <= count_d;
            full_q   <= full_d;
            nempty_q <= nempty_d;
        end
    end
endmodule

// File: tb/tb_issue_queue_int.sv
// Directed bench for issue_queue_int: reset, simple issue, fill/back-pressure,
// wakeup reorder, dispatch forwarding, simultaneous issue+dispatch, flush, async reset.
module tb_issue_queue_int;
    logic clk;
    logic reset;
    logic auto_issue;
    logic man_issue;
    int   n_checks;
    int   n_pass;

    issue_queue_int_if iq_if ();

    issue_queue_int #(.DEPTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (iq_if)
    );

    assign iq_if.issue_int = auto_issue ? iq_if.ready_int : man_issue;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] rs, input logic rsv,
                        input logic [5:0] rstag, input logic [31:0] rt, input logic rtv,
                        input logic [5:0] rttag, input logic [5:0] rd);
        iq_if.dispatch_valid   = 1'b1;
        iq_if.dispatch_opcode  = op;
        iq_if.dispatch_rsdata  = rs;
        iq_if.dispatch_rsvalid = rsv;
        iq_if.dispatch_rstag   = rstag;
        iq_if.dispatch_rtdata  = rt;
        iq_if.dispatch_rtvalid = rtv;
        iq_if.dispatch_rttag   = rttag;
        iq_if.dispatch_rdtag   = rd;
    endtask

    task automatic no_disp();
        iq_if.dispatch_valid = 1'b0;
    endtask

    task automatic cdb(input logic v, input logic [5:0] tag, input logic [31:0] data);
        iq_if.cdb_valid  = v;
        iq_if.cdb_tagout = tag;
        iq_if.cdb_out    = data;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        auto_issue = 1'b0;
        man_issue  = 1'b0;
        iq_if.flush = 1'b0;
        disp(4'h0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b0, 6'h0, 6'h0);
        no_disp();
        cdb(1'b0, 6'h0, 32'h0);
        #1;
        check("rst_ready_int", 32'(iq_if.ready_int), 32'd0);
        check("rst_full", 32'(iq_if.issuequeue_full), 32'd0);
        check("rst_nempty", 32'(iq_if.issuequeue_ready), 32'd0);
        check("rst_rdtag", 32'(iq_if.rdtag), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Simple path with issue tied to ready.
        auto_issue = 1'b1;
        disp(4'h1, 32'd5, 1'b1, 6'h0, 32'd7, 1'b1, 6'h0, 6'h03);
        tick();
        no_disp();
        check("s_ready_int", 32'(iq_if.ready_int), 32'd1);
        check("s_opcode", 32'(iq_if.opcode), 32'h1);
        check("s_rsdata", iq_if.rsdata, 32'd5);
        check("s_rtdata", iq_if.rtdata, 32'd7);
        check("s_rdtag", 32'(iq_if.rdtag), 32'h3);
        check("s_nempty", 32'(iq_if.issuequeue_ready), 32'd1);
        tick();
        check("s_ready_int_after", 32'(iq_if.ready_int), 32'd0);
        check("s_nempty_after", 32'(iq_if.issuequeue_ready), 32'd0);
        auto_issue = 1'b0;

        // Fill and back-pressure.
        for (int t = 1; t <= 4; t++) begin
            disp(4'h2, 32'(t), 1'b1, 6'h0, 32'(t + 100), 1'b1, 6'h0, 6'(t));
            tick();
        end
        check("f_full", 32'(iq_if.issuequeue_full), 32'd1);
        disp(4'h2, 32'd5, 1'b1, 6'h0, 32'd105, 1'b1, 6'h0, 6'd5);
        tick();
        no_disp();
        check("f_full_after_drop", 32'(iq_if.issuequeue_full), 32'd1);
        man_issue = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            check($sformatf("f_issue_rdtag%0d", t), 32'(iq_if.rdtag), 32'(t));
            tick();
        end
        man_issue = 1'b0;
        check("f_empty_ready_int", 32'(iq_if.ready_int), 32'd0);
        check("f_empty_nempty", 32'(iq_if.issuequeue_ready), 32'd0);
        check("f_empty_full", 32'(iq_if.issuequeue_full), 32'd0);

        // Wakeup reorder: A waits on tag 9, B ready issues first.
        disp(4'h3, 32'h0, 1'b0, 6'd9, 32'd2, 1'b1, 6'h0, 6'd10);
        tick();
        disp(4'h4, 32'd1, 1'b1, 6'h0, 32'd1, 1'b1, 6'h0, 6'd11);
        tick();
        no_disp();
        check("w_b_rdtag", 32'(iq_if.rdtag), 32'd11);
        man_issue = 1'b1;
        tick();
        man_issue = 1'b0;
        check("w_a_not_ready", 32'(iq_if.ready_int), 32'd0);
        cdb(1'b1, 6'd9, 32'hDEAD);
        #1;
        check("w_same_cycle_ready", 32'(iq_if.ready_int), 32'd0);
        tick();
        cdb(1'b0, 6'h0, 32'h0);
        check("w_a_ready", 32'(iq_if.ready_int), 32'd1);
        check("w_a_rsdata", iq_if.rsdata, 32'hDEAD);
        check("w_a_rdtag", 32'(iq_if.rdtag), 32'd10);
        man_issue = 1'b1;
        tick();
        man_issue = 1'b0;
        check("w_empty", 32'(iq_if.issuequeue_ready), 32'd0);

        // Dispatch forwarding from the same-cycle broadcast.
        disp(4'h5, 32'd1, 1'b1, 6'h0, 32'h0, 1'b0, 6'd12, 6'd20);
        cdb(1'b1, 6'd12, 32'h55);
        tick();
        no_disp();
        cdb(1'b0, 6'h0, 32'h0);
        check("d_ready_int", 32'(iq_if.ready_int), 32'd1);
        check("d_rtdata", iq_if.rtdata, 32'h55);
        check("d_rdtag", 32'(iq_if.rdtag), 32'd20);
        man_issue = 1'b1;
        tick();
        man_issue = 1'b0;

        // Simultaneous issue and dispatch at count 3.
        for (int t = 30; t <= 32; t++) begin
            disp(4'h6, 32'(t), 1'b1, 6'h0, 32'(t), 1'b1, 6'h0, 6'(t));
            tick();
        end
        disp(4'h6, 32'd33, 1'b1, 6'h0, 32'd33, 1'b1, 6'h0, 6'd33);
        man_issue = 1'b1;
        tick();
        no_disp();
        check("c_full", 32'(iq_if.issuequeue_full), 32'd0);
        for (int t = 31; t <= 33; t++) begin
            check($sformatf("c_order_rdtag%0d", t), 32'(iq_if.rdtag), 32'(t));
            tick();
        end
        man_issue = 1'b0;
        check("c_empty", 32'(iq_if.issuequeue_ready), 32'd0);

        // Flush with 3 entries and a concurrent dispatch.
        for (int t = 40; t <= 42; t++) begin
            disp(4'h7, 32'(t), 1'b1, 6'h0, 32'(t), 1'b1, 6'h0, 6'(t));
            tick();
        end
        disp(4'h7, 32'd43, 1'b1, 6'h0, 32'd43, 1'b1, 6'h0, 6'd43);
        iq_if.flush = 1'b1;
        tick();
        iq_if.flush = 1'b0;
        no_disp();
        check("fl_ready_int", 32'(iq_if.ready_int), 32'd0);
        check("fl_nempty", 32'(iq_if.issuequeue_ready), 32'd0);
        check("fl_full", 32'(iq_if.issuequeue_full), 32'd0);
        disp(4'h8, 32'd44, 1'b1, 6'h0, 32'd44, 1'b1, 6'h0, 6'd44);
        tick();
        disp(4'h8, 32'd45, 1'b1, 6'h0, 32'd45, 1'b1, 6'h0, 6'd45);
        check("fl_post_rdtag", 32'(iq_if.rdtag), 32'd44);
        tick();
        no_disp();

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check("ar_ready_int", 32'(iq_if.ready_int), 32'd0);
        check("ar_nempty", 32'(iq_if.issuequeue_ready), 32'd0);
        check("ar_rdtag", 32'(iq_if.rdtag), 32'd0);
        check("ar_rsdata", iq_if.rsdata, 32'd0);
        #2;
        reset = 1'b0;
        disp(4'h9, 32'd46, 1'b1, 6'h0, 32'd46, 1'b1, 6'h0, 6'd46);
        tick();
        no_disp();
        check("ar_first_disp", 32'(iq_if.rdtag), 32'd46);
        check("ar_first_nempty", 32'(iq_if.issuequeue_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/issue_queue_int.md
# issue_queue_int

Integer-class issue queue that sits directly upstream of the issue unit. It accepts dispatched integer/branch instructions from the dispatch stage and holds up to `DEPTH` of them. It snoops the common data bus (CDB) to capture pending source operands. Each cycle it presents the oldest fully-ready entry to the issue unit on `ready_int`/`opcode`/`rsdata`/`rtdata`/`rdtag`, and retires that entry when the issue unit grants it via `issue_int`.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; must be ≥2.
- `CNT_W`, 3: width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `dispatch_valid`  input  1  dispatch offers an instruction this cycle.
- `dispatch_opcode`  input  4  ALU opcode.
- `dispatch_rsdata`, `dispatch_rtdata`  input  32  source operand values; meaningful only when the matching `*valid` is 1.
- `dispatch_rstag`, `dispatch_rttag`  input  6  producer tags for operands that are not yet ready.
- `dispatch_rsvalid`, `dispatch_rtvalid`  input  1  operand value already available.
- `dispatch_rdtag`  input  6  destination tag.
- `cdb_valid`  input  1  CDB broadcast valid.
- `cdb_tagout`  input  6  CDB broadcast tag.
- `cdb_out`  input  32  CDB broadcast data.
- `flush`  input  1  synchronous squash of all entries (mispredict).
- `issue_int`  input  1  grant from the issue unit; may depend combinationally on `ready_int`.
- `issuequeue_full`  output  1  registered; count == `DEPTH`.
- `issuequeue_ready`  output  1  registered; count != 0.
- `ready_int`  output  1  at least one entry has both operands valid.
- `opcode`  output  4  opcode of the selected entry.
- `rsdata`, `rtdata`  output  32  operand values of the selected entry.
- `rdtag`  output  6  destination tag of the selected entry.

## Operation
- **Storage.** An age-ordered compacting array. Entry 0 is the oldest. Each entry holds: `v`, opcode, rsdata/rstag/rsv, rtdata/rttag/rtv, rdtag.
- **Select.** Choose the lowest-index entry with `v & rsv & rtv`.
  - `ready_int` = a selected entry exists.
  - `opcode`/`rsdata`/`rtdata`/`rdtag` are driven combinationally from that entry.
  - When no entry is selected, all four are driven to 0.
- **Issue.** When `ready_int & issue_int`, the selected entry k is removed at the edge. Entries k+1..count-1 shift down by one. `issue_int` is ignored when `ready_int` = 0.
- **Dispatch.** Accepted when `dispatch_valid & ~issuequeue_full & ~flush`.
  - The accepted instruction is written to slot count (or count−1 if an issue happens in the same cycle), i.e. directly behind the youngest entry after compaction.
  - Dispatch while full is dropped silently, even if an issue occurs in that same cycle. Dispatch must respect `issuequeue_full`.
- **Wakeup.** When `cdb_valid`, every valid entry with `rsv=0` and `rstag==cdb_tagout` loads `cdb_out` and sets `rsv`. The rt operand is handled the same way.
  - Wakeup applies to the shifted position of an entry when a shift happens in the same cycle.
- **Dispatch forwarding.** For an incoming operand with `*valid=0` whose tag equals `cdb_tagout` while `cdb_valid`, capture `cdb_out` and write that operand as valid.
- **Count.** count' = count + accept − issue_fire.
- **Flush.** Clears all `v` bits and count at the next edge. Flush has priority over dispatch and issue. `issue_int` in the flush cycle still completes in the issue unit, but the queue state is cleared regardless.
- **Reset.** All `v`=0, count=0. All outputs are 0: `ready_int`=0, `issuequeue_full`=0, `issuequeue_ready`=0, data and tag outputs 0.

## Timing
- A dispatched entry with both operands valid asserts `ready_int` in the cycle after acceptance. Minimum dispatch-to-issue latency is 1 cycle.
- A CDB wakeup takes effect the cycle after the broadcast. Select never uses the same-cycle CDB value.
- An entry is removed at the edge where `ready_int & issue_int`. The next-oldest ready entry is presented in the following cycle.
- `issuequeue_full`/`issuequeue_ready` reflect the count after the edge, with no combinational path from inputs. Back-to-back dispatch at one per cycle is sustained until full. Issue is at most one per cycle.
- Asynchronous reset takes effect immediately, mid-operation. The first dispatch is accepted at the first edge after deassertion.

## Test plan
- **Reset, then simple path.** Reset, then dispatch opcode=4'h1, rs=5, rt=7 (both valid), rdtag=6'h03 with `issue_int` tied to `ready_int` → one cycle later `ready_int`=1, rsdata=5, rtdata=7, rdtag=3. The next cycle `ready_int`=0 and `issuequeue_ready`=0.
- **Fill and back-pressure.** With `issue_int`=0, dispatch 4 ready entries (tags 1..4) → `issuequeue_full`=1. A 5th dispatch (tag 5) is dropped. Then grant 4 times → rdtags issue in order 1, 2, 3, 4, and no tag 5 ever appears.
- **Wakeup reorder.** Dispatch entry A (rs waits on tag 9), then entry B (ready) → B issues first. Broadcast `cdb_valid`, tag 9, data 32'hDEAD → the next cycle A is presented with rsdata=32'hDEAD.
- **Dispatch forwarding.** Dispatch an entry with rt pending on tag 12 in the same cycle as a CDB broadcast of tag 12, data 32'h55 → the next cycle `ready_int`=1, rtdata=32'h55.
- **Simultaneous issue and dispatch at count 3.** Count stays 3. The new entry lands at the youngest slot, and age order is preserved on subsequent issues.
- **Flush and async reset.**
  - Assert `flush` with 3 entries and a concurrent dispatch → the next cycle count=0, `ready_int`=0, `issuequeue_ready`=0.
  - Assert `reset` between clock edges while the queue is non-empty → outputs go to 0 immediately, without waiting for a clock edge.
